soc_test_monitor: RTL and testbench
===================================

SOC_TEST_MONITOR -- requirements
Module: soc_test_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of snooped core/data-memory channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 32, meaning data-bus and result width.
REQ-003 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-004 SHALL have parameter FLAG_ADDR, default 32'h0, meaning byte address of the completion-flag word.
REQ-005 SHALL have parameter RESULT_ADDR, default 32'h4, meaning byte address of the result word.
REQ-006 SHALL have parameter CNT_W, default 16, meaning cycle-counter and timeout width.
REQ-007 SHALL have parameter WAIT_ALL, default 1, meaning 1 = finish when all channels flag, 0 = finish when any channel flags.
REQ-008 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-009 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-010 SHALL have port start_i, input, 1, arm/re-arm pulse.
REQ-011 SHALL have port timeout_cycles_i, input, CNT_W, timeout limit; 0 disables the timeout.
REQ-012 SHALL have ports dmem_req_i / dmem_we_i, input, NUM_CH, per-channel request and write enable.
REQ-013 SHALL have ports dmem_addr_i / dmem_wdata_i, input, NUM_CH x ADDR_W / NUM_CH x DATA_W, packed per-channel address and write data.
REQ-014 SHALL have port busy_o, output, 1, high in RUN.
REQ-015 SHALL have ports done_o / timeout_o / pass_o, output, 1 each: finished, timed out, all flagged channels passed.
REQ-016 SHALL have port ch_done_o, output, NUM_CH, sticky per-channel flag seen.
REQ-017 SHALL have port result_o, output, NUM_CH x DATA_W, latched per-channel result.
REQ-018 SHALL have port cycle_count_o, output, CNT_W, cycles spent in RUN.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DONE, TOUT.
REQ-020 SHALL treat a snooped write as req & we & (addr[ADDR_W-1:2] == target[ADDR_W-1:2]); byte offset bits are ignored; reads are ignored.
REQ-021 SHALL, in RUN, set ch_done[c] and ch_pass[c] = (wdata == PASS_CODE) at the edge ending a flag write with nonzero wdata on channel c; zero-data flag writes are ignored.
REQ-022 SHALL latch result_o[c] on a RESULT_ADDR write in RUN only while ch_done[c] is 0; last write before the flag wins.
REQ-023 SHALL evaluate completion on (ch_done | this-cycle flag sets), AND-reduced if WAIT_ALL else OR-reduced, so done_o rises at the same edge as the final ch_done_o bit.
REQ-024 SHALL increment cycle_count_o every RUN cycle, saturating at all-ones.
REQ-025 SHALL enter TOUT when timeout_cycles_i != 0 and cycle_count_o + 1 == timeout_cycles_i without completion; completion in the same cycle wins (DONE).
REQ-026 SHALL drive pass_o = done_o & AND of ch_pass over done channels; pass_o is 0 in TOUT.
REQ-027 SHALL hold DONE/TOUT and all captured outputs until start_i or reset.
REQ-028 SHALL, on start_i in any state (including mid-RUN), clear counter, ch_done, ch_pass, result_o and enter RUN next edge; snooped writes in the start_i cycle are discarded.

Reset
REQ-029 SHALL, on rst_i, go to IDLE with busy_o, done_o, timeout_o, pass_o, ch_done_o, result_o and cycle_count_o all 0; reset overrides start_i.

Structure
REQ-030 SHALL place the state enum and PASS_CODE (= 1) in package soc_mon_pkg.
REQ-031 SHALL instantiate NUM_CH copies of sub-module soc_mon_channel (address decode, ch_done/ch_pass/result registers).

Verification
REQ-032 NUM_CH=2, WAIT_ALL=1: ch0 writes 0x4<-55 then 0x0<-1, later ch1 writes 0x4<-21 then 0x0<-1 -> done_o at ch1 flag edge, pass_o=1, result_o={21,55}.
REQ-033 WAIT_ALL=0: ch1 writes flag 2 -> done_o=1, pass_o=0, ch_done_o=2'b10.
REQ-034 timeout_cycles_i=100, no flags -> timeout_o=1 after exactly 100 RUN cycles, cycle_count_o=100; flag at cycle 100 instead -> done_o, not timeout.
REQ-035 Result write after flag (0x4<-99) -> result_o unchanged; flag write with data 0 or read at 0x0 -> no ch_done.
REQ-036 start_i mid-RUN and rst_i during DONE -> all outputs cleared per REQ-028/REQ-029.

Source files
------------

// File: rtl/soc_mon_pkg.sv
// Shared types and constants for the SoC test-completion monitor.
package soc_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_TOUT = 2'd3
  } state_t;

  localparam int unsigned PASS_CODE = 1;

endpackage

// File: rtl/soc_mon_channel.sv
// One snooped channel: decodes flag/result writes and keeps the sticky flag, pass bit and result.
module soc_mon_channel
  import soc_mon_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] FLAG_ADDR   = '0,
  parameter logic [ADDR_W-1:0] RESULT_ADDR = 'h4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:2] word_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              flag_set,
  output logic              ch_done,
  output logic              ch_pass,
  output logic [DATA_W-1:0] result
);

  logic wr;
  logic flag_hit;
  logic result_hit;

  // Byte-offset bits never reach this module, so any byte within the word matches.
  assign wr         = en & req & we;
  assign flag_hit   = wr & (word_addr == FLAG_ADDR[ADDR_W-1:2]);
  assign result_hit = wr & (word_addr == RESULT_ADDR[ADDR_W-1:2]) & ~ch_done;
  assign flag_set   = flag_hit & (wdata != '0) & ~ch_done;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ch_done <= 1'b0;
      ch_pass <= 1'b0;
      result  <= '0;
    end else begin
      if (flag_set) begin
        ch_done <= 1'b1;
        ch_pass <= (wdata == DATA_W'(PASS_CODE));
      end
      if (result_hit) begin
        result <= wdata;
      end
    end
  end

endmodule

// File: rtl/soc_test_monitor.sv
// Snoops per-core data-memory writes for completion flags and results, with a RUN-cycle timeout.
module soc_test_monitor
  import soc_mon_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] FLAG_ADDR   = '0,
  parameter logic [ADDR_W-1:0] RESULT_ADDR = 'h4,
  parameter int CNT_W    = 16,
  parameter int WAIT_ALL = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [CNT_W-1:0]         timeout_cycles_i,
  input  logic [NUM_CH-1:0]        dmem_req_i,
  input  logic [NUM_CH-1:0]        dmem_we_i,
  input  logic [NUM_CH*ADDR_W-1:0] dmem_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] dmem_wdata_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     timeout_o,
  output logic                     pass_o,
  output logic [NUM_CH-1:0]        ch_done_o,
  output logic [NUM_CH*DATA_W-1:0] result_o,
  output logic [CNT_W-1:0]         cycle_count_o
);

  state_t            state;
  logic              run_en;
  logic              complete;
  logic              tout_hit;
  logic [NUM_CH-1:0] flag_set;
  logic [NUM_CH-1:0] ch_pass;
  logic [NUM_CH-1:0] done_mask;
  logic [CNT_W:0]    count_inc;

  // Writes in the start_i cycle are discarded because the channels are being cleared.
  assign run_en = (state == ST_RUN) && !start_i;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    soc_mon_channel #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .FLAG_ADDR   (FLAG_ADDR),
      .RESULT_ADDR (RESULT_ADDR)
    ) u_ch (
      .clk       (clk_i),
      .rst       (rst_i),
      .clr       (start_i),
      .en        (run_en),
      .req       (dmem_req_i[c]),
      .we        (dmem_we_i[c]),
      .word_addr (dmem_addr_i[c*ADDR_W+2 +: ADDR_W-2]),
      .wdata     (dmem_wdata_i[c*DATA_W +: DATA_W]),
      .flag_set  (flag_set[c]),
      .ch_done   (ch_done_o[c]),
      .ch_pass   (ch_pass[c]),
      .result    (result_o[c*DATA_W +: DATA_W])
    );
  end

  // Including this cycle's flag sets lets done_o rise together with the last ch_done_o bit.
  assign done_mask = ch_done_o | flag_set;
  assign complete  = (WAIT_ALL != 0) ? (&done_mask) : (|done_mask);
  assign count_inc = {1'b0, cycle_count_o} + {{CNT_W{1'b0}}, 1'b1};
  assign tout_hit  = (timeout_cycles_i != '0) && (count_inc == {1'b0, timeout_cycles_i});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      cycle_count_o <= '0;
    end else if (start_i) begin
      state         <= ST_RUN;
      cycle_count_o <= '0;
    end else if (state == ST_RUN) begin
      if (cycle_count_o != '1) begin
        cycle_count_o <= count_inc[CNT_W-1:0];
      end
      if (complete) begin
        state <= ST_DONE;
      end else if (tout_hit) begin
        state <= ST_TOUT;
      end
    end
  end

  assign busy_o    = (state == ST_RUN);
  assign done_o    = (state == ST_DONE);
  assign timeout_o = (state == ST_TOUT);
  assign pass_o    = done_o & (&(ch_pass | ~ch_done_o));

endmodule

// File: tb/tb_soc_test_monitor.sv
// Directed bench: one monitor waiting on all channels, one finishing on any channel, same stimulus.
module tb_soc_test_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] tmo;
  logic [1:0]  req, we;
  logic [63:0] addr, wdata;

  logic        busy_a, done_a, tout_a, pass_a;
  logic [1:0]  chd_a;
  logic [63:0] res_a;
  logic [15:0] cnt_a;
  logic        busy_y, done_y, tout_y, pass_y;
  logic [1:0]  chd_y;
  logic [63:0] res_y;
  logic [15:0] cnt_y;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  soc_test_monitor #(.NUM_CH(2), .WAIT_ALL(1)) u_all (
    .clk_i(clk), .rst_i(rst), .start_i(start), .timeout_cycles_i(tmo),
    .dmem_req_i(req), .dmem_we_i(we), .dmem_addr_i(addr), .dmem_wdata_i(wdata),
    .busy_o(busy_a), .done_o(done_a), .timeout_o(tout_a), .pass_o(pass_a),
    .ch_done_o(chd_a), .result_o(res_a), .cycle_count_o(cnt_a)
  );

  soc_test_monitor #(.NUM_CH(2), .WAIT_ALL(0)) u_any (
    .clk_i(clk), .rst_i(rst), .start_i(start), .timeout_cycles_i(tmo),
    .dmem_req_i(req), .dmem_we_i(we), .dmem_addr_i(addr), .dmem_wdata_i(wdata),
    .busy_o(busy_y), .done_o(done_y), .timeout_o(tout_y), .pass_o(pass_y),
    .ch_done_o(chd_y), .result_o(res_y), .cycle_count_o(cnt_y)
  );

  typedef struct {
    logic        start;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] a0, a1, d0, d1;
    logic        busy, done, pass;
    logic [1:0]  chd;
    logic [31:0] r0, r1;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(logic s, logic [1:0] rq, logic [1:0] w,
                              logic [31:0] a0, logic [31:0] a1, logic [31:0] d0, logic [31:0] d1,
                              logic b, logic dn, logic p, logic [1:0] cd,
                              logic [31:0] r0, logic [31:0] r1, logic [15:0] c);
    vec_t v;
    v.start = s; v.req = rq; v.we = w; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.busy = b; v.done = dn; v.pass = p; v.chd = cd; v.r0 = r0; v.r1 = r1; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    req = '0; we = '0; addr = '0; wdata = '0; start = 1'b0;
  endtask

  task automatic put(input int ch, input logic w, input logic [31:0] a, input logic [31:0] d);
    req[ch] = 1'b1;
    we[ch]  = w;
    addr[ch*32 +: 32]  = a;
    wdata[ch*32 +: 32] = d;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_done"}, {63'd0, done_a}, 64'd0);
    chk({tag, "_tout"}, {63'd0, tout_a}, 64'd0);
    chk({tag, "_pass"}, {63'd0, pass_a}, 64'd0);
    chk({tag, "_chd"},  {62'd0, chd_a}, 64'd0);
    chk({tag, "_res"},  res_a, 64'd0);
    chk({tag, "_cnt"},  {48'd0, cnt_a}, 64'd0);
  endtask

  vec_t tbl[8];

  initial begin
    rst = 1'b1; tmo = '0;
    idle_bus();
    tick(); tick();
    chk_cleared("rst");
    chk("rst_busy", {63'd0, busy_a}, 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", {63'd0, busy_a}, 64'd0);

    // Both channels report, done rises at ch1 flag edge, later result write is ignored.
    tbl[0] = mk(1, 2'b00, 2'b00, 0, 0, 0,  0,  1, 0, 0, 2'b00, 0,  0,  0);
    tbl[1] = mk(0, 2'b01, 2'b01, 4, 0, 55, 0,  1, 0, 0, 2'b00, 55, 0,  1);
    tbl[2] = mk(0, 2'b01, 2'b01, 0, 0, 1,  0,  1, 0, 0, 2'b01, 55, 0,  2);
    tbl[3] = mk(0, 2'b00, 2'b00, 0, 0, 0,  0,  1, 0, 0, 2'b01, 55, 0,  3);
    tbl[4] = mk(0, 2'b10, 2'b10, 0, 4, 0,  21, 1, 0, 0, 2'b01, 55, 21, 4);
    tbl[5] = mk(0, 2'b10, 2'b10, 0, 0, 0,  1,  0, 1, 1, 2'b11, 55, 21, 5);
    tbl[6] = mk(0, 2'b01, 2'b01, 4, 0, 99, 0,  0, 1, 1, 2'b11, 55, 21, 5);
    tbl[7] = mk(0, 2'b00, 2'b00, 0, 0, 0,  0,  0, 1, 1, 2'b11, 55, 21, 5);
    for (int i = 0; i < 8; i++) begin
      start = tbl[i].start; req = tbl[i].req; we = tbl[i].we;
      addr  = {tbl[i].a1, tbl[i].a0};
      wdata = {tbl[i].d1, tbl[i].d0};
      tick();
      chk($sformatf("v%0d_busy", i), {63'd0, busy_a}, {63'd0, tbl[i].busy});
      chk($sformatf("v%0d_done", i), {63'd0, done_a}, {63'd0, tbl[i].done});
      chk($sformatf("v%0d_pass", i), {63'd0, pass_a}, {63'd0, tbl[i].pass});
      chk($sformatf("v%0d_chd", i),  {62'd0, chd_a},  {62'd0, tbl[i].chd});
      chk($sformatf("v%0d_res", i),  res_a,           {tbl[i].r1, tbl[i].r0});
      chk($sformatf("v%0d_cnt", i),  {48'd0, cnt_a},  {48'd0, tbl[i].cnt});
    end
    idle_bus();

    // Any-channel mode: a non-pass flag finishes without pass.
    start = 1'b1; tick(); start = 1'b0;
    put(1, 1'b1, 32'h0, 32'd2); tick(); idle_bus();
    chk("any_done", {63'd0, done_y}, 64'd1);
    chk("any_pass", {63'd0, pass_y}, 64'd0);
    chk("any_chd",  {62'd0, chd_y},  64'd2);
    chk("all_still_busy", {63'd0, busy_a}, 64'd1);
    chk("all_chd_fail",   {62'd0, chd_a},  64'd2);

    // Reads and zero-data flag writes are ignored; byte offset in the result address is ignored.
    start = 1'b1; tick(); start = 1'b0;
    put(0, 1'b0, 32'h0, 32'd1); tick(); idle_bus();
    chk("read_no_flag", {62'd0, chd_a}, 64'd0);
    put(0, 1'b1, 32'h0, 32'd0); tick(); idle_bus();
    chk("zero_no_flag", {62'd0, chd_a}, 64'd0);
    put(0, 1'b1, 32'h5, 32'd7); tick(); idle_bus();
    chk("res_offset", res_a, 64'd7);
    put(0, 1'b1, 32'h2, 32'd1); tick(); idle_bus();
    chk("flag_offset", {62'd0, chd_a}, 64'd1);
    put(0, 1'b1, 32'h4, 32'd99); tick(); idle_bus();
    chk("res_after_flag", res_a, 64'd7);
    chk("mid_cnt", {48'd0, cnt_a}, 64'd5);

    // Restart mid-RUN; the flag write in the start cycle is discarded.
    start = 1'b1; put(1, 1'b1, 32'h0, 32'd1); tick(); idle_bus();
    chk("restart_busy", {63'd0, busy_a}, 64'd1);
    chk_cleared("restart");
    tick();
    chk("restart_cnt1", {48'd0, cnt_a}, 64'd1);

    // Timeout after exactly 100 RUN cycles, then held.
    rst = 1'b1; tick(); rst = 1'b0;
    tmo = 16'd100;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 99; i++) tick();
    chk("tmo_99_busy", {63'd0, busy_a}, 64'd1);
    chk("tmo_99_cnt",  {48'd0, cnt_a}, 64'd99);
    chk("tmo_99_tout", {63'd0, tout_a}, 64'd0);
    tick();
    chk("tmo_tout", {63'd0, tout_a}, 64'd1);
    chk("tmo_cnt",  {48'd0, cnt_a}, 64'd100);
    chk("tmo_busy", {63'd0, busy_a}, 64'd0);
    chk("tmo_pass", {63'd0, pass_a}, 64'd0);
    tick(); tick(); tick();
    chk("tmo_hold_tout", {63'd0, tout_a}, 64'd1);
    chk("tmo_hold_cnt",  {48'd0, cnt_a}, 64'd100);

    // Completion in the timeout cycle wins.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 99; i++) tick();
    put(0, 1'b1, 32'h0, 32'd1); put(1, 1'b1, 32'h0, 32'd1); tick(); idle_bus();
    chk("race_done", {63'd0, done_a}, 64'd1);
    chk("race_tout", {63'd0, tout_a}, 64'd0);
    chk("race_pass", {63'd0, pass_a}, 64'd1);
    chk("race_cnt",  {48'd0, cnt_a}, 64'd100);

    // Reset in DONE overrides a simultaneous start.
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
    chk("rstdone_busy", {63'd0, busy_a}, 64'd0);
    chk_cleared("rstdone");
    tick();
    chk("rstdone_idle", {63'd0, busy_a}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
